// File: rtl/alu_exec_pkg.sv
// rtl/alu_exec_pkg.sv - shared opcode encodings, ROB tag and width constants for the execute unit
package alu_exec_pkg;

    localparam int DATA_W_DEF    = 32;
    localparam int ROB_TAG_W_DEF = 4;
    localparam int OP_W_DEF      = 6;

    localparam logic [ROB_TAG_W_DEF-1:0] ZERO_TAG_ROB = '0;

    typedef enum logic [OP_W_DEF-1:0] {
        OP_NOP = 6'd0,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } alu_op_e;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_MUL,
        MD_DIV,
        MD_DONE
    } md_state_e;

    function automatic logic is_muldiv(alu_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_div(alu_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - iterative RV32M unit: 32-step shift-add multiply, 32-step restoring divide plus sign fixup
module alu_muldiv
    import alu_exec_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              flush,
    input  logic              start,
    input  alu_op_e           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              idle,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    md_state_e           state, state_next;
    logic [CNT_W-1:0]    cnt;
    logic [2*DATA_W-1:0] acc, mcand, prod;
    logic [DATA_W-1:0]   mplier, quo, rem, divisor;
    logic [DATA_W-1:0]   a_mag, b_mag;
    logic [DATA_W:0]     div_tmp;
    logic                div_ge, sa, sb, neg_res, neg_rem;
    alu_op_e             op_q;

    // Work on magnitudes; signs are reapplied at the end.
    always_comb begin
        sa      = a[DATA_W-1] && (op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        sb      = b[DATA_W-1] && (op inside {OP_MULH, OP_DIV, OP_REM});
        a_mag   = sa ? -a : a;
        b_mag   = sb ? -b : b;
        div_tmp = {rem, quo[DATA_W-1]};
        div_ge  = div_tmp >= {1'b0, divisor};
    end

    always_comb begin
        state_next = state;
        case (state)
            MD_IDLE: if (start) state_next = is_div(op) ? MD_DIV : MD_MUL;
            MD_MUL:  if (cnt == CNT_W'(DATA_W - 1)) state_next = MD_DONE;
            MD_DIV:  if (cnt == CNT_W'(DATA_W)) state_next = MD_DONE;
            MD_DONE: state_next = MD_IDLE;
            default: state_next = MD_IDLE;
        endcase
        if (!en)   state_next = state;
        if (flush) state_next = MD_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= MD_IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            quo     <= '0;
            rem     <= '0;
            divisor <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            op_q    <= OP_NOP;
        end else if (flush) begin
            cnt <= '0;
        end else if (en) begin
            case (state)
                MD_IDLE: if (start) begin
                    cnt     <= '0;
                    op_q    <= op;
                    acc     <= '0;
                    mcand   <= {{DATA_W{1'b0}}, a_mag};
                    mplier  <= b_mag;
                    quo     <= a_mag;
                    rem     <= '0;
                    divisor <= b_mag;
                    // Divide by zero keeps an all-ones quotient and returns the dividend as remainder.
                    neg_res <= (sa ^ sb) && (b != '0);
                    neg_rem <= sa;
                end
                MD_MUL: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                end
                MD_DIV: begin
                    if (cnt != CNT_W'(DATA_W)) begin
                        rem <= div_ge ? DATA_W'(div_tmp - {1'b0, divisor}) : div_tmp[DATA_W-1:0];
                        quo <= {quo[DATA_W-2:0], div_ge};
                    end else begin
                        quo <= neg_res ? -quo : quo;
                        rem <= neg_rem ? -rem : rem;
                    end
                    cnt <= cnt + 1'b1;
                end
                MD_DONE: cnt <= '0;
                default: cnt <= '0;
            endcase
        end
    end

    always_comb begin
        prod = neg_res ? -acc : acc;
        case (op_q)
            OP_MUL:                        result = prod[DATA_W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  result = prod[2*DATA_W-1:DATA_W];
            OP_DIV, OP_DIVU:               result = quo;
            default:                       result = rem;
        endcase
    end

    assign idle = (state == MD_IDLE);
    assign done = (state == MD_DONE);

endmodule

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - RV32I execute unit with CDB broadcast; ALU_MULDIV_EN adds the iterative RV32M unit
module alu_exec
    import alu_exec_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ROB_TAG_W = ROB_TAG_W_DEF,
    parameter int OP_W      = OP_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 in_flush,
    input  logic [OP_W-1:0]      in_rs_op,
    input  logic [DATA_W-1:0]    in_rs_value1,
    input  logic [DATA_W-1:0]    in_rs_value2,
    input  logic [DATA_W-1:0]    in_rs_imm,
    input  logic [ROB_TAG_W-1:0] in_rs_rob_tag,
    input  logic [DATA_W-1:0]    in_rs_pc,
    output logic                 out_rs_ready,
    output logic [ROB_TAG_W-1:0] out_cdb_tag,
    output logic [DATA_W-1:0]    out_cdb_value,
    output logic                 out_cdb_jump,
    output logic [DATA_W-1:0]    out_cdb_target
);

    alu_op_e              op;
    logic [DATA_W-1:0]    op2, res_value, res_target, br_target, link;
    logic [4:0]           shamt;
    logic                 res_jump, accept, md_issue, md_done;
    logic [DATA_W-1:0]    md_result;
    logic [ROB_TAG_W-1:0] pend_tag;

    assign op        = alu_op_e'(OP_W_DEF'(in_rs_op));
    assign br_target = in_rs_pc + in_rs_imm;
    assign link      = in_rs_pc + DATA_W'(4);

    always_comb begin
        op2 = in_rs_value2;
        if (op inside {OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI})
            op2 = in_rs_imm;
        shamt      = op2[4:0];
        res_value  = '0;
        res_target = '0;
        res_jump   = 1'b0;
        case (op)
            OP_ADD,  OP_ADDI:  res_value = in_rs_value1 + op2;
            OP_SUB:            res_value = in_rs_value1 - op2;
            OP_SLL,  OP_SLLI:  res_value = in_rs_value1 << shamt;
            OP_SLT,  OP_SLTI:  res_value = DATA_W'($signed(in_rs_value1) < $signed(op2));
            OP_SLTU, OP_SLTIU: res_value = DATA_W'(in_rs_value1 < op2);
            OP_XOR,  OP_XORI:  res_value = in_rs_value1 ^ op2;
            OP_SRL,  OP_SRLI:  res_value = in_rs_value1 >> shamt;
            OP_SRA,  OP_SRAI:  res_value = $unsigned($signed(in_rs_value1) >>> shamt);
            OP_OR,   OP_ORI:   res_value = in_rs_value1 | op2;
            OP_AND,  OP_ANDI:  res_value = in_rs_value1 & op2;
            OP_LUI:            res_value = in_rs_imm;
            OP_AUIPC:          res_value = br_target;
            OP_JAL: begin
                res_value  = link;
                res_target = br_target;
                res_jump   = 1'b1;
            end
            OP_JALR: begin
                res_value  = link;
                res_target = (in_rs_value1 + in_rs_imm) & ~DATA_W'(1);
                res_jump   = 1'b1;
            end
            OP_BEQ:  begin res_target = br_target; res_jump = in_rs_value1 == in_rs_value2; end
            OP_BNE:  begin res_target = br_target; res_jump = in_rs_value1 != in_rs_value2; end
            OP_BLT:  begin res_target = br_target; res_jump = $signed(in_rs_value1) <  $signed(in_rs_value2); end
            OP_BGE:  begin res_target = br_target; res_jump = $signed(in_rs_value1) >= $signed(in_rs_value2); end
            OP_BLTU: begin res_target = br_target; res_jump = in_rs_value1 <  in_rs_value2; end
            OP_BGEU: begin res_target = br_target; res_jump = in_rs_value1 >= in_rs_value2; end
            default: ;
        endcase
    end

    assign accept = rdy && out_rs_ready && (op != OP_NOP) && !in_flush;

`ifdef ALU_MULDIV_EN
    logic md_idle;

    assign md_issue     = accept && is_muldiv(op);
    assign out_rs_ready = md_idle;

    alu_muldiv #(.DATA_W(DATA_W)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .en     (rdy),
        .flush  (in_flush),
        .start  (md_issue),
        .op     (op),
        .a      (in_rs_value1),
        .b      (in_rs_value2),
        .idle   (md_idle),
        .done   (md_done),
        .result (md_result)
    );
`else
    // Without the RV32M unit its opcodes fall through the single-cycle path as zero.
    assign md_issue     = 1'b0;
    assign md_done      = 1'b0;
    assign md_result    = '0;
    assign out_rs_ready = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_cdb_tag    <= ROB_TAG_W'(ZERO_TAG_ROB);
            out_cdb_value  <= '0;
            out_cdb_jump   <= 1'b0;
            out_cdb_target <= '0;
            pend_tag       <= ROB_TAG_W'(ZERO_TAG_ROB);
        end else begin
            out_cdb_tag <= ROB_TAG_W'(ZERO_TAG_ROB);
            if (rdy && !in_flush) begin
                if (md_done) begin
                    out_cdb_tag    <= pend_tag;
                    out_cdb_value  <= md_result;
                    out_cdb_jump   <= 1'b0;
                    out_cdb_target <= '0;
                end else if (accept && !md_issue) begin
                    out_cdb_tag    <= in_rs_rob_tag;
                    out_cdb_value  <= res_value;
                    out_cdb_jump   <= res_jump;
                    out_cdb_target <= res_target;
                end
                if (md_issue) pend_tag <= in_rs_rob_tag;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - scoreboard bench for alu_exec; RV32M checks compiled in with ALU_MULDIV_EN
module tb_alu_exec;
    import alu_exec_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b0;
    logic        in_flush = 1'b0;
    logic [5:0]  in_rs_op = '0;
    logic [31:0] in_rs_value1 = '0;
    logic [31:0] in_rs_value2 = '0;
    logic [31:0] in_rs_imm = '0;
    logic [3:0]  in_rs_rob_tag = '0;
    logic [31:0] in_rs_pc = '0;
    logic        out_rs_ready;
    logic [3:0]  out_cdb_tag;
    logic [31:0] out_cdb_value;
    logic        out_cdb_jump;
    logic [31:0] out_cdb_target;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] value;
        logic        jump;
        logic [31:0] target;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    alu_exec dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .in_flush       (in_flush),
        .in_rs_op       (in_rs_op),
        .in_rs_value1   (in_rs_value1),
        .in_rs_value2   (in_rs_value2),
        .in_rs_imm      (in_rs_imm),
        .in_rs_rob_tag  (in_rs_rob_tag),
        .in_rs_pc       (in_rs_pc),
        .out_rs_ready   (out_rs_ready),
        .out_cdb_tag    (out_cdb_tag),
        .out_cdb_value  (out_cdb_value),
        .out_cdb_jump   (out_cdb_jump),
        .out_cdb_target (out_cdb_target)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=0x%h required=0x%h", name, act, req);
        end
    endtask

    // lat < 0: the issue must not produce any broadcast.
    task automatic issue(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tag,
                         input logic [31:0] ev, input logic ej, input logic [31:0] et, input int lat);
        exp_t e;
        @(negedge clk);
        in_rs_op      = op;
        in_rs_value1  = a;
        in_rs_value2  = b;
        in_rs_imm     = imm;
        in_rs_pc      = pc;
        in_rs_rob_tag = tag;
        if (lat >= 0) begin
            e.tag    = tag;
            e.value  = ev;
            e.jump   = ej;
            e.target = et;
            e.cyc    = cyc + 1 + lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_rs_op = OP_NOP;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!out_rs_ready && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wait_idle_ready", {31'd0, out_rs_ready}, 32'd1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            tests++;
            fails++;
            $display("FAIL cdb_missing actual=none required=tag %0d by cycle %0d", e.tag, e.cyc);
        end
        if (out_cdb_tag != 4'd0) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL cdb_unexpected actual=tag %0d value 0x%h required=no broadcast",
                         out_cdb_tag, out_cdb_value);
            end else begin
                e = sb.pop_front();
                chk("cdb_tag", {28'd0, out_cdb_tag}, {28'd0, e.tag});
                chk("cdb_value", out_cdb_value, e.value);
                chk("cdb_jump", {31'd0, out_cdb_jump}, {31'd0, e.jump});
                chk("cdb_target", out_cdb_target, e.target);
                chk("cdb_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tag", {28'd0, out_cdb_tag}, 32'd0);
        chk("reset_value", out_cdb_value, 32'd0);
        chk("reset_jump", {31'd0, out_cdb_jump}, 32'd0);
        chk("reset_target", out_cdb_target, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ready_after_reset", {31'd0, out_rs_ready}, 32'd1);

        //     op         v1            v2            imm           pc        tag   value         jump  target    lat
        issue(OP_ADD,   32'd5,        32'hFFFFFFFF, 32'd0,        32'd0,    4'd3, 32'd4,        1'b0, 32'd0,    0);
        issue(OP_SUB,   32'd3,        32'd5,        32'd0,        32'd0,    4'd1, 32'hFFFFFFFE, 1'b0, 32'd0,    0);
        issue(OP_SRA,   32'h80000000, 32'h24,       32'd0,        32'd0,    4'd2, 32'hF8000000, 1'b0, 32'd0,    0);
        issue(OP_SRLI,  32'h80000000, 32'd0,        32'd4,        32'd0,    4'd4, 32'h08000000, 1'b0, 32'd0,    0);
        issue(OP_SLTI,  32'hFFFFFFFF, 32'd0,        32'd1,        32'd0,    4'd5, 32'd1,        1'b0, 32'd0,    0);
        issue(OP_SLTU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,    4'd6, 32'd0,        1'b0, 32'd0,    0);
        issue(OP_SLLI,  32'd1,        32'd0,        32'h1F,       32'd0,    4'd7, 32'h80000000, 1'b0, 32'd0,    0);
        issue(OP_XORI,  32'h0000F0F0, 32'd0,        32'h0000FFFF, 32'd0,    4'd8, 32'h00000F0F, 1'b0, 32'd0,    0);
        issue(OP_AND,   32'hFF00FF00, 32'h0FF00FF0, 32'd0,        32'd0,    4'd9, 32'h0F000F00, 1'b0, 32'd0,    0);
        issue(OP_LUI,   32'd0,        32'd0,        32'h12345000, 32'd0,    4'd10, 32'h12345000, 1'b0, 32'd0,   0);
        issue(OP_AUIPC, 32'd0,        32'd0,        32'h1000,     32'h100,  4'd11, 32'h1100,    1'b0, 32'd0,    0);
        issue(OP_JAL,   32'd0,        32'd0,        32'h10,       32'h40,   4'd12, 32'h44,      1'b1, 32'h50,   0);
        issue(OP_JALR,  32'h1003,     32'd0,        32'd2,        32'h40,   4'd13, 32'h44,      1'b1, 32'h1004, 0);
        issue(OP_BLT,   32'hFFFFFFFF, 32'd1,        32'h20,       32'h100,  4'd14, 32'd0,       1'b1, 32'h120,  0);
        issue(OP_BLTU,  32'hFFFFFFFF, 32'd1,        32'h20,       32'h100,  4'd15, 32'd0,       1'b0, 32'h120,  0);
        issue(OP_BEQ,   32'd7,        32'd7,        32'hFFFFFFF0, 32'h200,  4'd1, 32'd0,        1'b1, 32'h1F0,  0);
        issue(OP_BNE,   32'd7,        32'd7,        32'hFFFFFFF0, 32'h200,  4'd2, 32'd0,        1'b0, 32'h1F0,  0);
        issue(OP_BGE,   32'hFFFFFFFF, 32'd1,        32'h8,        32'h10,   4'd3, 32'd0,        1'b0, 32'h18,   0);
        issue(OP_BGEU,  32'hFFFFFFFF, 32'd1,        32'h8,        32'h10,   4'd4, 32'd0,        1'b1, 32'h18,   0);

        in_flush = 1'b1;
        issue(OP_ADD, 32'd1, 32'd1, 32'd0, 32'd0, 4'd5, 32'd0, 1'b0, 32'd0, -1);
        in_flush = 1'b0;
        rdy = 1'b0;
        issue(OP_ADD, 32'd1, 32'd1, 32'd0, 32'd0, 4'd6, 32'd0, 1'b0, 32'd0, -1);
        rdy = 1'b1;
        issue(OP_OR, 32'h00F0, 32'h0F00, 32'd0, 32'd0, 4'd7, 32'h0FF0, 1'b0, 32'd0, 0);

`ifdef ALU_MULDIV_EN
        issue(OP_DIV, 32'd7, 32'd0, 32'd0, 32'd0, 4'd5, 32'hFFFFFFFF, 1'b0, 32'd0, 34);
        for (int k = 0; k < 34; k++) begin
            chk("div_busy_ready", {31'd0, out_rs_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        chk("div_done_ready", {31'd0, out_rs_ready}, 32'd1);

        issue(OP_MULH, 32'h80000000, 32'h80000000, 32'd0, 32'd0, 4'd6, 32'h40000000, 1'b0, 32'd0, 33);
        issue(OP_ADD, 32'd1, 32'd2, 32'd0, 32'd0, 4'd9, 32'd0, 1'b0, 32'd0, -1);
        wait_idle();
        issue(OP_MUL,    32'd7,        32'hFFFFFFFD, 32'd0, 32'd0, 4'd1, 32'hFFFFFFEB, 1'b0, 32'd0, 33); wait_idle();
        issue(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 4'd2, 32'hFFFFFFFE, 1'b0, 32'd0, 33); wait_idle();
        issue(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 4'd3, 32'hFFFFFFFF, 1'b0, 32'd0, 33); wait_idle();
        issue(OP_DIV,    32'hFFFFFFF9, 32'd2,        32'd0, 32'd0, 4'd4, 32'hFFFFFFFD, 1'b0, 32'd0, 34); wait_idle();
        issue(OP_REM,    32'hFFFFFFF9, 32'd2,        32'd0, 32'd0, 4'd5, 32'hFFFFFFFF, 1'b0, 32'd0, 34); wait_idle();
        issue(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0, 4'd6, 32'h80000000, 1'b0, 32'd0, 34); wait_idle();
        issue(OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0, 4'd7, 32'd0,        1'b0, 32'd0, 34); wait_idle();
        issue(OP_DIVU,   32'd100,      32'd7,        32'd0, 32'd0, 4'd8, 32'd14,       1'b0, 32'd0, 34); wait_idle();
        issue(OP_REMU,   32'd100,      32'd7,        32'd0, 32'd0, 4'd9, 32'd2,        1'b0, 32'd0, 34); wait_idle();
        issue(OP_REM,    32'd7,        32'd0,        32'd0, 32'd0, 4'd10, 32'd7,       1'b0, 32'd0, 34); wait_idle();

        issue(OP_DIV, 32'd100, 32'd7, 32'd0, 32'd0, 4'd11, 32'd0, 1'b0, 32'd0, -1);
        repeat (9) @(posedge clk);
        #1;
        in_flush = 1'b1;
        @(posedge clk);
        #1;
        in_flush = 1'b0;
        chk("flush_ready", {31'd0, out_rs_ready}, 32'd1);
        repeat (40) @(posedge clk);
        #1;

        issue(OP_DIV, 32'd100, 32'd7, 32'd0, 32'd0, 4'd12, 32'd0, 1'b0, 32'd0, -1);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("async_reset_ready", {31'd0, out_rs_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("reset_abort_ready", {31'd0, out_rs_ready}, 32'd1);
        repeat (40) @(posedge clk);
        #1;

        issue(OP_MUL, 32'd7, 32'hFFFFFFFD, 32'd0, 32'd0, 4'd13, 32'hFFFFFFEB, 1'b0, 32'd0, 38);
        repeat (9) @(posedge clk);
        #1;
        rdy = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rdy = 1'b1;
        wait_idle();
`else
        issue(OP_MUL, 32'd7, 32'd3, 32'd0, 32'd0, 4'd2, 32'd0, 1'b0, 32'd0, 0);
        chk("nomd_ready", {31'd0, out_rs_ready}, 32'd1);
        issue(OP_DIV, 32'd7, 32'd0, 32'd0, 32'd0, 4'd3, 32'd0, 1'b0, 32'd0, 0);
`endif

        repeat (10) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have parameter ROB_TAG_W, default 4, ROB tag width; tag 0 = ZERO_TAG_ROB = no valid tag.
REQ-003 SHALL have parameter OP_W, default 6, internal opcode width; value NOP = idle.
REQ-004 Ports, in order: clk in 1, rising-edge clock; rst in 1, asynchronous active-low reset; rdy in 1, global enable; in_flush in 1, misprediction clear; in_rs_op in OP_W, opcode from RS (NOP = no issue); in_rs_value1 in DATA_W; in_rs_value2 in DATA_W; in_rs_imm in DATA_W; in_rs_rob_tag in ROB_TAG_W; in_rs_pc in DATA_W; out_rs_ready out 1, may issue this cycle; out_cdb_tag out ROB_TAG_W (0 = no broadcast); out_cdb_value out DATA_W; out_cdb_jump out 1, control transfer taken; out_cdb_target out DATA_W, redirect PC.

Function
REQ-005 Issue accepted at a rising edge when rdy=1, out_rs_ready=1, in_rs_op!=NOP, in_flush=0.
REQ-006 Single-cycle ops: result on out_cdb_* for exactly one cycle after the accept edge; out_cdb_tag=0 in every other cycle.
REQ-007 R-type: op2=value2; I-type: op2=imm; shifts use op2[4:0]; SRA arithmetic; SLT signed, SLTU unsigned; all arithmetic mod 2^32.
REQ-008 LUI: value=imm; AUIPC: value=pc+imm; both jump=0.
REQ-009 JAL: value=pc+4, target=pc+imm, jump=1; JALR: value=pc+4, target=(value1+imm)&~1, jump=1.
REQ-010 BEQ/BNE/BLT/BGE/BLTU/BGEU: value=0, target=pc+imm, jump=compare outcome.
REQ-011 Non-control ops: jump=0, target=0.
REQ-012 FSM states IDLE, MUL, DIV, DONE; out_rs_ready=1 only in IDLE.
REQ-013 IDLE->MUL or DIV on accepted muldiv op; MUL 32 iterations, DIV 33 (incl. sign fixup); then DONE one cycle driving CDB, then IDLE.
REQ-014 Accept edge = edge 0: MUL* result on CDB after edge 33, DIV/REM after edge 34.
REQ-015 Divide by zero: quotient=0xFFFFFFFF, remainder=dividend; 0x80000000 / -1: quotient=0x80000000, remainder=0.
REQ-016 in_rs_op!=NOP while out_rs_ready=0 SHALL be ignored (RS must not issue).
REQ-017 in_flush=1 at an edge: FSM->IDLE, pending result dropped, out_cdb_tag=0 next cycle; flush wins over simultaneous issue.
REQ-018 rdy=0: no accept, FSM and iteration counter frozen, out_cdb_tag=0.

Reset
REQ-019 rst=0 asynchronously: FSM=IDLE, counter=0, out_cdb_tag=0, out_cdb_value=0, out_cdb_jump=0, out_cdb_target=0; out_rs_ready=1 after release.
REQ-020 Reset mid-iteration SHALL abort with no CDB broadcast after release.

Configuration
REQ-021 Macro ALU_MULDIV_EN defined: RV32M ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) via FSM per REQ-012..015.
REQ-022 Macro undefined: no FSM/datapath, out_rs_ready tied 1, RV32M opcodes produce value=0, jump=0 in one cycle.

Structure
REQ-023 Opcode encodings, NOP, ZERO_TAG_ROB, widths SHALL live in the shared constants package used by RS and decoder.
REQ-024 Iterative multiplier/divider SHALL be sub-module alu_muldiv (start/op/operands in, done/result out).
REQ-025 Total RTL 120-400 lines.

Verification
REQ-026 ADD v1=5 v2=0xFFFFFFFF tag=3 -> next cycle tag=3 value=4 jump=0, following cycle tag=0.
REQ-027 BLT v1=0xFFFFFFFF v2=1 pc=0x100 imm=0x20 -> value=0 jump=1 target=0x120; BLTU same operands -> jump=0.
REQ-028 JALR v1=0x1003 imm=2 pc=0x40 -> value=0x44 target=0x1004 jump=1.
REQ-029 (ALU_MULDIV_EN) DIV 7/0 tag=5 -> out_rs_ready=0 edges 1-34, after edge 34 tag=5 value=0xFFFFFFFF; MULH 0x80000000*0x80000000 -> value=0x40000000 after edge 33.
REQ-030 DIV issued, in_flush at edge 10 -> no tag broadcast, out_rs_ready=1 next cycle; repeat with rst low at edge 10 -> same.
REQ-031 rdy low for 5 cycles during MUL -> result delayed exactly 5 cycles, value unchanged.
